// File: rtl/invaders_pkg.sv
// Shared geometry, movement steps, start position and fleet state encoding
// for the invader fleet and its helpers.
package invaders_pkg;

    localparam int CELL_W    = 32;
    localparam int CELL_H    = 24;
    localparam int BOX_OFF_X = 4;
    localparam int BOX_OFF_Y = 4;
    localparam int BOX_W     = 24;
    localparam int BOX_H     = 16;
    localparam int STEP_X    = 8;
    localparam int STEP_Y    = 16;

    localparam logic [9:0] START_X = 10'd64;
    localparam logic [9:0] START_Y = 10'd48;

    typedef enum logic [2:0] {
        MARCH,
        STEP,
        DROP,
        CLEARED,
        LANDED
    } fleet_state_t;

endpackage

// File: rtl/fleet_extent.sv
// Combinational bounds of the live fleet: leftmost and rightmost occupied
// column and the lowest occupied row. All zeros when nothing is alive.
module fleet_extent
    import invaders_pkg::*;
#(
    parameter int ROWS  = 4,
    parameter int COLS  = 8,
    parameter int COL_W = 3,
    parameter int ROW_W = 2
) (
    input  logic [ROWS*COLS-1:0] alive,
    output logic [COL_W-1:0]     left_col,
    output logic [COL_W-1:0]     right_col,
    output logic [ROW_W-1:0]     bottom_row
);

    logic [COLS-1:0] col_any;
    logic [ROWS-1:0] row_any;

    always_comb begin
        col_any = '0;
        row_any = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (alive[r*COLS+c]) begin
                    col_any[c] = 1'b1;
                    row_any[r] = 1'b1;
                end
            end
        end
    end

    // Scanning in opposite directions lets the last match win for each bound.
    always_comb begin
        left_col   = '0;
        right_col  = '0;
        bottom_row = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (col_any[c]) left_col = COL_W'(c);
        end
        for (int c = 0; c < COLS; c++) begin
            if (col_any[c]) right_col = COL_W'(c);
        end
        for (int r = 0; r < ROWS; r++) begin
            if (row_any[r]) bottom_row = ROW_W'(r);
        end
    end

endmodule

// File: rtl/invader_fleet.sv
// Marching alien fleet: paced stepping that speeds up as aliens die, edge
// drops, projectile hit detection and win/lose terminal states.
module invader_fleet
    import invaders_pkg::*;
#(
    parameter int ROWS            = 4,
    parameter int COLS            = 8,
    parameter int TICKS_PER_ALIEN = 2500,
    parameter int SCREEN_W        = 640,
    parameter int PLAYER_Y        = 440
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 proj_valid,
    input  logic [9:0]           proj_x,
    input  logic [9:0]           proj_y,
    output logic                 collision,
    output logic [9:0]           fleet_x,
    output logic [9:0]           fleet_y,
    output logic [ROWS*COLS-1:0] alive,
    output logic [5:0]           aliens_left,
    output logic                 all_dead,
    output logic                 landed
);

    localparam int N     = ROWS * COLS;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CNT_W = $clog2(TICKS_PER_ALIEN * N + 1);

    fleet_state_t state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [CNT_W:0]   cnt_inc, limit;
    logic             dir_right, dir_next;
    logic [9:0]       x_next, y_next;
    logic [N-1:0]     hit_vec, alive_next;
    logic [5:0]       left_next;
    logic             hit_any, query, playing;
    logic [COLS-1:0]  col_hit;
    logic [ROWS-1:0]  row_hit;
    logic [COL_W-1:0] left_col, right_col;
    logic [ROW_W-1:0] bottom_row;
    logic [10:0]      px, py, fx, fy;
    logic             edge_right, edge_left, touch_down;

    assign playing = (state != CLEARED) && (state != LANDED);
    assign query   = enable && proj_valid && playing;
    assign px      = {1'b0, proj_x};
    assign py      = {1'b0, proj_y};
    assign fx      = {1'b0, fleet_x};
    assign fy      = {1'b0, fleet_y};

    // Boxes never overlap, so per-column and per-row hits combine into at most one alien.
    always_comb begin
        col_hit = '0;
        row_hit = '0;
        hit_vec = '0;
        for (int c = 0; c < COLS; c++) begin
            col_hit[c] = (px >= fx + 11'(c*CELL_W + BOX_OFF_X)) &&
                         (px <  fx + 11'(c*CELL_W + BOX_OFF_X + BOX_W));
        end
        for (int r = 0; r < ROWS; r++) begin
            row_hit[r] = (py >= fy + 11'(r*CELL_H + BOX_OFF_Y)) &&
                         (py <  fy + 11'(r*CELL_H + BOX_OFF_Y + BOX_H));
        end
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                hit_vec[r*COLS+c] = query && row_hit[r] && col_hit[c] && alive[r*COLS+c];
            end
        end
    end

    assign hit_any    = |hit_vec;
    assign alive_next = alive & ~hit_vec;
    assign left_next  = aliens_left - {5'd0, hit_any};

    // Bounds follow the post-hit bitmap so a column emptied this cycle is already ignored.
    fleet_extent #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) u_extent (
        .alive      (alive_next),
        .left_col   (left_col),
        .right_col  (right_col),
        .bottom_row (bottom_row)
    );

    assign edge_right = fx + (11'(right_col) + 11'd1) * 11'(CELL_W) + 11'(STEP_X) > 11'(SCREEN_W);
    assign edge_left  = fx + 11'(left_col) * 11'(CELL_W) < 11'(STEP_X);
    assign touch_down = {1'b0, fleet_y + 10'(STEP_Y)} + (11'(bottom_row) + 11'd1) * 11'(CELL_H)
                        >= 11'(PLAYER_Y);

    assign limit   = (CNT_W+1)'(TICKS_PER_ALIEN * int'(aliens_left));
    assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        dir_next   = dir_right;
        x_next     = fleet_x;
        y_next     = fleet_y;
        case (state)
            MARCH: begin
                if (enable) begin
                    if (cnt_inc >= limit) begin
                        state_next = STEP;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_inc[CNT_W-1:0];
                    end
                end
            end
            STEP: begin
                if (enable && left_next != 6'd0) begin
                    if (dir_right ? edge_right : edge_left) begin
                        state_next = DROP;
                    end else begin
                        x_next     = dir_right ? fleet_x + 10'(STEP_X) : fleet_x - 10'(STEP_X);
                        state_next = MARCH;
                    end
                end
            end
            DROP: begin
                if (enable && left_next != 6'd0) begin
                    y_next     = fleet_y + 10'(STEP_Y);
                    dir_next   = ~dir_right;
                    state_next = touch_down ? LANDED : MARCH;
                end
            end
            default: ;
        endcase
        if (playing && left_next == 6'd0) state_next = CLEARED;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= MARCH;
            cnt         <= '0;
            dir_right   <= 1'b1;
            fleet_x     <= START_X;
            fleet_y     <= START_Y;
            alive       <= '1;
            aliens_left <= 6'(N);
            collision   <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            dir_right   <= dir_next;
            fleet_x     <= x_next;
            fleet_y     <= y_next;
            alive       <= alive_next;
            aliens_left <= left_next;
            collision   <= hit_any;
        end
    end

    assign all_dead = (state == CLEARED);
    assign landed   = (state == LANDED);

endmodule

// File: tb/tb_invader_fleet.sv
// Self-checking bench for invader_fleet: directed tables and sequences plus
// random projectile traffic, all compared every cycle against a pixel-level model.
module tb_invader_fleet;

    localparam int ROWS = 4;
    localparam int COLS = 8;
    localparam int N    = ROWS * COLS;
    localparam int TPA  = 1;
    localparam int SW   = 640;
    localparam int PY   = 440;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic         proj_valid = 1'b0;
    logic [9:0]   proj_x = '0;
    logic [9:0]   proj_y = '0;
    logic         collision, all_dead, landed;
    logic [9:0]   fleet_x, fleet_y;
    logic [N-1:0] alive;
    logic [5:0]   aliens_left;

    int total = 0;
    int bad   = 0;

    // Model: position, direction, interval progress, pending move (0 none, 1 side step, 2 drop),
    // outcome (0 playing, 1 won, 2 landed).
    int           m_x, m_y, m_cnt, m_pending, m_done, m_left;
    bit           m_right, m_coll;
    logic [N-1:0] m_alive;

    typedef struct {
        bit en;
        bit pv;
        int dx;
        int dy;
        bit coll;
        int left;
    } vec_t;

    vec_t vecs[11];

    invader_fleet #(
        .ROWS            (ROWS),
        .COLS            (COLS),
        .TICKS_PER_ALIEN (TPA),
        .SCREEN_W        (SW),
        .PLAYER_Y        (PY)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .proj_valid  (proj_valid),
        .proj_x      (proj_x),
        .proj_y      (proj_y),
        .collision   (collision),
        .fleet_x     (fleet_x),
        .fleet_y     (fleet_y),
        .alive       (alive),
        .aliens_left (aliens_left),
        .all_dead    (all_dead),
        .landed      (landed)
    );

    always #5 clk = ~clk;

    task automatic check(string name, longint actual, longint expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic int leftmost(logic [N-1:0] a);
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                if (a[r*COLS+c]) return c;
        return 0;
    endfunction

    function automatic int rightmost(logic [N-1:0] a);
        for (int c = COLS - 1; c >= 0; c--)
            for (int r = 0; r < ROWS; r++)
                if (a[r*COLS+c]) return c;
        return 0;
    endfunction

    function automatic int bottom(logic [N-1:0] a);
        for (int r = ROWS - 1; r >= 0; r--)
            for (int c = 0; c < COLS; c++)
                if (a[r*COLS+c]) return r;
        return 0;
    endfunction

    function automatic int model_hit(int px, int py);
        int dx, dy, c, r;
        if (px < m_x || py < m_y) return -1;
        dx = px - m_x;
        dy = py - m_y;
        c  = dx / 32;
        r  = dy / 24;
        if (c >= COLS || r >= ROWS) return -1;
        if (dx % 32 < 4 || dx % 32 >= 28 || dy % 24 < 4 || dy % 24 >= 20) return -1;
        if (!m_alive[r*COLS+c]) return -1;
        return r * COLS + c;
    endfunction

    task automatic model_reset();
        m_x = 64; m_y = 48; m_right = 1'b1; m_cnt = 0; m_pending = 0;
        m_done = 0; m_alive = '1; m_left = N; m_coll = 1'b0;
    endtask

    task automatic model_edge(bit en, bit pv, int px, int py);
        int idx, nl;
        logic [N-1:0] na;
        idx = (en && pv && m_done == 0) ? model_hit(px, py) : -1;
        na = m_alive;
        if (idx >= 0) na[idx] = 1'b0;
        nl = $countones(na);
        m_coll = (idx >= 0);
        if (m_done == 0 && en) begin
            if (m_pending == 0) begin
                if (m_cnt + 1 >= TPA * m_left) begin
                    m_pending = 1;
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end else if (nl > 0) begin
                if (m_pending == 1) begin
                    if (m_right ? (m_x + (rightmost(na) + 1) * 32 + 8 > SW)
                                : (m_x + leftmost(na) * 32 < 8)) begin
                        m_pending = 2;
                    end else begin
                        m_x += m_right ? 8 : -8;
                        m_pending = 0;
                    end
                end else begin
                    m_y += 16;
                    m_right = !m_right;
                    m_pending = 0;
                    if (m_y + (bottom(na) + 1) * 24 >= PY) m_done = 2;
                end
            end
        end
        if (m_done == 0 && nl == 0) m_done = 1;
        m_alive = na;
        m_left  = nl;
    endtask

    task automatic check_output();
        check("collision", collision, m_coll);
        check("fleet_x", fleet_x, m_x);
        check("fleet_y", fleet_y, m_y);
        check("alive", alive, m_alive);
        check("aliens_left", aliens_left, m_left);
        check("all_dead", all_dead, m_done == 1);
        check("landed", landed, m_done == 2);
    endtask

    task automatic apply_stimulus(bit en, bit pv, int px, int py);
        enable     = en;
        proj_valid = pv;
        proj_x     = 10'(px);
        proj_y     = 10'(py);
        model_edge(en, pv, px, py);
        @(posedge clk);
        #1;
        check_output();
    endtask

    task automatic hit_alien(int idx);
        apply_stimulus(1'b1, 1'b1, m_x + (idx % COLS) * 32 + 12, m_y + (idx / COLS) * 24 + 10);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        enable = 1'b0;
        proj_valid = 1'b0;
        proj_x = '0;
        proj_y = '0;
        model_reset();
        #2;
        check("rst_collision", collision, 0);
        check("rst_fleet_x", fleet_x, 64);
        check("rst_fleet_y", fleet_y, 48);
        check("rst_alive", alive, 32'hFFFF_FFFF);
        check("rst_aliens_left", aliens_left, 32);
        check("rst_all_dead", all_dead, 0);
        check("rst_landed", landed, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic first_step_check(string tag);
        for (int i = 0; i < 32; i++) apply_stimulus(1'b1, 1'b0, 0, 0);
        check({tag, "_x_before_step"}, fleet_x, 64);
        apply_stimulus(1'b1, 1'b0, 0, 0);
        check({tag, "_x_after_step"}, fleet_x, 72);
    endtask

    initial begin
        int x0, y0, px, py, guard;

        vecs[0]  = '{1'b1, 1'b1, 100, 28, 1'b1, 31};
        vecs[1]  = '{1'b1, 1'b1, 100, 28, 1'b0, 31};
        vecs[2]  = '{1'b1, 1'b1, 100, 28, 1'b0, 31};
        vecs[3]  = '{1'b1, 1'b1, 30, 12, 1'b0, 31};
        vecs[4]  = '{1'b1, 1'b1, 3, 4, 1'b0, 31};
        vecs[5]  = '{1'b1, 1'b1, 4, 4, 1'b1, 30};
        vecs[6]  = '{1'b1, 1'b1, 59, 19, 1'b1, 29};
        vecs[7]  = '{1'b1, 1'b1, 92, 4, 1'b0, 29};
        vecs[8]  = '{1'b1, 1'b1, 228, 76, 1'b1, 28};
        vecs[9]  = '{1'b1, 1'b1, 228, 92, 1'b0, 28};
        vecs[10] = '{1'b0, 1'b1, 68, 4, 1'b0, 28};

        #1;
        do_reset();
        first_step_check("first");

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].en, vecs[i].pv, m_x + vecs[i].dx, m_y + vecs[i].dy);
            check($sformatf("vec%0d_collision", i), collision, vecs[i].coll);
            check($sformatf("vec%0d_left", i), aliens_left, vecs[i].left);
        end
        check("vec_bit11_clear", alive[11], 0);

        // Hit landing on the same edge as a side step.
        guard = 0;
        while (m_pending != 1 && guard < 200) begin
            apply_stimulus(1'b1, 1'b0, 0, 0);
            guard++;
        end
        check("step_wait_timeout", guard < 200, 1);
        x0 = m_x;
        hit_alien(3);
        check("step_hit_collision", collision, 1);
        check("step_hit_alive3", alive[3], 0);
        check("step_hit_x", fleet_x, x0 + 8);

        // Empty column 7, then march right until the fleet drops.
        for (int r = 0; r < ROWS; r++)
            if (m_alive[r*COLS+7]) hit_alien(r * COLS + 7);
        guard = 0;
        while (fleet_y == 10'd48 && guard < 6000) begin
            apply_stimulus(1'b1, 1'b0, 0, 0);
            guard++;
        end
        check("drop_timeout", guard < 6000, 1);
        check("drop_x", fleet_x, 416);
        check("drop_y", fleet_y, 64);
        guard = 0;
        while (fleet_x == 10'd416 && guard < 200) begin
            apply_stimulus(1'b1, 1'b0, 0, 0);
            guard++;
        end
        check("after_drop_left_x", fleet_x, 408);

        for (int i = 0; i < 600; i++) begin
            px = m_x + int'($urandom_range(0, 263)) - 4;
            py = m_y + int'($urandom_range(0, 100)) - 4;
            if (px < 0) px = 0;
            if (py < 0) py = 0;
            apply_stimulus($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0, px, py);
        end

        // Reset while in the step cycle, then again while collision is high.
        do_reset();
        guard = 0;
        while (m_pending != 1 && guard < 200) begin
            apply_stimulus(1'b1, 1'b0, 0, 0);
            guard++;
        end
        do_reset();
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b0, 0, 0);
        hit_alien(5);
        check("pre_reset_collision", collision, 1);
        do_reset();
        first_step_check("rerun");

        // Clear the whole fleet: win state, no more movement or hits.
        do_reset();
        for (int i = 0; i < N; i++) hit_alien(i);
        check("win_all_dead", all_dead, 1);
        check("win_left", aliens_left, 0);
        x0 = m_x;
        y0 = m_y;
        for (int i = 0; i < 40; i++) apply_stimulus(1'b1, 1'b1, x0 + 12, y0 + 10);
        check("win_x_frozen", fleet_x, x0);
        check("win_y_frozen", fleet_y, y0);
        check("win_no_collision", collision, 0);

        // Leave one bottom-row alien so the fleet keeps dropping until it lands.
        do_reset();
        for (int i = 0; i < N; i++)
            if (i != 24) hit_alien(i);
        guard = 0;
        while (!landed && guard < 10000) begin
            apply_stimulus(1'b1, 1'b0, 0, 0);
            guard++;
        end
        check("land_timeout", guard < 10000, 1);
        check("land_y", fleet_y, 352);
        check("land_all_dead", all_dead, 0);
        x0 = m_x;
        for (int i = 0; i < 20; i++) apply_stimulus(1'b1, 1'b0, 0, 0);
        check("land_x_frozen", fleet_x, x0);
        check("land_still", landed, 1);

        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
